// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_pkg
// Description : Shared types and constants for the two-master I/O bus arbiter.
//               Provides the owner/state encoding, default bus widths, master
//               id constants and a saturating burst-counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package io_pkg;

  // Registered bus owner / arbiter state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_state_e;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  // Master ids; the id is also the tag carried with every read
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Burst counter increment that stops at the configured limit
  function automatic logic [3:0] bcnt_sat_inc(input logic [3:0] cnt, input logic [3:0] lim);
    return (cnt >= lim) ? cnt : cnt + 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : io_rd_tag_pipe
// Description : DEPTH-stage shift register carrying {valid, master id} for
//               every read strobe, so returning data is steered to the master
//               that issued the read regardless of later owner changes.
// Ports       : clk, rst        - clock, async active-high reset
//               i_vld / i_id    - read strobe issued this cycle and its master
//               o_vld / o_id    - read data valid on the I/O block this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module io_rd_tag_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_vld,
  input  logic i_id,
  output logic o_vld,
  output logic o_id
);

  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] r_id;

  // Reset clears every stage so in-flight reads never return
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_id  <= '0;
    end else begin
      r_vld[0] <= i_vld;
      r_id[0]  <= i_id;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_id[i]  <= r_id[i-1];
      end
    end
  end

  assign o_vld = r_vld[DEPTH-1];
  assign o_id  = r_id[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/io_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : io_bus_arbiter
// Description : Shares the single-port I/O register bus between the CPU (M0)
//               and a secondary master (M1). Round-robin with a bounded burst
//               per owner, zero-wait combinational grant, registered command
//               to the I/O block, read data returned to the issuing master.
// Ports       : clk, rst                 - clock, async active-high reset
//               mX_req/we/addr/wdata     - command from master X (held until gnt)
//               mX_gnt                   - command accepted this cycle
//               mX_rvalid / mX_rdata     - read return pulse and data
//               io_we/io_re/io_addr/io_data_in - registered command to I/O block
//               io_data_out              - read data from I/O block
// Revision    : 1.0 - initial release
// ============================================================================
module io_bus_arbiter
  import io_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int READ_LAT  = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              io_we,
  output logic              io_re,
  output logic [ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_data_in,
  input  logic [DATA_W-1:0] io_data_out
);

  localparam logic [3:0] C_MAX_BURST = 4'(MAX_BURST);

  owner_state_e      r_state;
  owner_state_e      w_state_nxt;
  logic [3:0]        r_bcnt;
  logic [3:0]        w_bcnt_nxt;
  logic              r_last;
  logic              w_last_nxt;
  logic              w_sel;
  logic              w_acc;
  logic              w_cmd_we;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic [DATA_W-1:0] w_cmd_wdata;

  logic              r_io_we;
  logic              r_io_re;
  logic [ADDR_W-1:0] r_io_addr;
  logic [DATA_W-1:0] r_io_data_in;
  logic              r_rd_id;

  logic              w_ret_vld;
  logic              w_ret_id;

  // --------------------------------------------------------------------------
  // Selection: owner keeps the bus while under its burst limit or while the
  // other master is quiet; from IDLE a tie goes to the master not served last.
  // --------------------------------------------------------------------------
  always_comb begin
    w_sel = M0;
    case (r_state)
      OWN0: begin
        if (m0_req && (!m1_req || (r_bcnt < C_MAX_BURST))) w_sel = M0;
        else if (m1_req)                                  w_sel = M1;
        else                                              w_sel = M0;
      end
      OWN1: begin
        if (m1_req && (!m0_req || (r_bcnt < C_MAX_BURST))) w_sel = M1;
        else if (m0_req)                                  w_sel = M0;
        else                                              w_sel = M1;
      end
      default: begin
        if (m0_req && m1_req) w_sel = ~r_last;
        else if (m1_req)      w_sel = M1;
        else                  w_sel = M0;
      end
    endcase
  end

  // Grants are forced low while reset is asserted
  assign m0_gnt = m0_req & (w_sel == M0) & ~rst;
  assign m1_gnt = m1_req & (w_sel == M1) & ~rst;
  assign w_acc  = m0_gnt | m1_gnt;

  assign w_cmd_we    = (w_sel == M1) ? m1_we    : m0_we;
  assign w_cmd_addr  = (w_sel == M1) ? m1_addr  : m0_addr;
  assign w_cmd_wdata = (w_sel == M1) ? m1_wdata : m0_wdata;

  // --------------------------------------------------------------------------
  // Next-state: any accept makes the acceptor owner; an idle cycle drops to
  // IDLE and clears the burst count but remembers who was served last.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = IDLE;
    w_bcnt_nxt  = 4'd0;
    w_last_nxt  = r_last;
    if (w_acc) begin
      w_last_nxt  = w_sel;
      w_state_nxt = (w_sel == M1) ? OWN1 : OWN0;
      if (((r_state == OWN0) && (w_sel == M0)) || ((r_state == OWN1) && (w_sel == M1)))
        w_bcnt_nxt = bcnt_sat_inc(r_bcnt, C_MAX_BURST);
      else
        w_bcnt_nxt = 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_bcnt  <= 4'd0;
      r_last  <= M1;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Registered command toward the I/O block; address/data hold when idle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_io_we      <= 1'b0;
      r_io_re      <= 1'b0;
      r_io_addr    <= '0;
      r_io_data_in <= '0;
      r_rd_id      <= M0;
    end else begin
      r_io_we <= w_acc &  w_cmd_we;
      r_io_re <= w_acc & ~w_cmd_we;
      if (w_acc) begin
        r_io_addr    <= w_cmd_addr;
        r_io_data_in <= w_cmd_wdata;
        r_rd_id      <= w_sel;
      end
    end
  end

  assign io_we      = r_io_we;
  assign io_re      = r_io_re;
  assign io_addr    = r_io_addr;
  assign io_data_in = r_io_data_in;

  // Tag pipe is fed by the issued read strobe, so its exit lines up with the
  // cycle in which io_data_out carries that read's result.
  io_rd_tag_pipe #(
    .DEPTH (READ_LAT)
  ) u_rd_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_vld (r_io_re),
    .i_id  (r_rd_id),
    .o_vld (w_ret_vld),
    .o_id  (w_ret_id)
  );

  assign m0_rvalid = w_ret_vld & (w_ret_id == M0);
  assign m1_rvalid = w_ret_vld & (w_ret_id == M1);
  assign m0_rdata  = rst ? '0 : io_data_out;
  assign m1_rdata  = rst ? '0 : io_data_out;

endmodule
`default_nettype wire

// File: tb/tb_io_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_bus_arbiter
// Description : Directed self-checking bench for io_bus_arbiter with a small
//               I/O block model (registered read data, one cycle latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       m0_req, m0_we, m1_req, m1_we;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic       m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [7:0] m0_rdata, m1_rdata;
  logic       io_we, io_re;
  logic [7:0] io_addr, io_data_in;
  logic [7:0] io_data_out = 8'h00;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  io_bus_arbiter #(
    .ADDR_W(8), .DATA_W(8), .READ_LAT(1), .MAX_BURST(4)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .io_we(io_we), .io_re(io_re), .io_addr(io_addr), .io_data_in(io_data_in),
    .io_data_out(io_data_out)
  );

  // I/O block model: registered read data; 0x20 holds 0x3C, others read back their address
  always @(posedge clk) begin
    if (io_re) io_data_out <= (io_addr == 8'h20) ? 8'h3C : io_addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_sel;
    logic prev_sel;
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    tick(); tick();

    // Reset state
    chk("rst_io_we", io_we, 0);
    chk("rst_io_re", io_re, 0);
    chk("rst_io_addr", io_addr, 0);
    chk("rst_gnts", {m0_gnt, m1_gnt}, 0);
    chk("rst_rvalids", {m0_rvalid, m1_rvalid}, 0);
    rst = 1'b0;

    // M0 write 0x10 / 0xA5
    m0_req = 1; m0_we = 1; m0_addr = 8'h10; m0_wdata = 8'hA5;
    #1;
    chk("wr_m0_gnt", m0_gnt, 1);
    chk("wr_m1_gnt", m1_gnt, 0);
    tick();
    m0_req = 0;
    chk("wr_io_we", io_we, 1);
    chk("wr_io_re", io_re, 0);
    chk("wr_io_addr", io_addr, 8'h10);
    chk("wr_io_data", io_data_in, 8'hA5);
    tick();
    chk("wr_io_we_drop", io_we, 0);
    chk("wr_addr_hold", io_addr, 8'h10);

    // M1 read 0x20 -> 0x3C after one cycle
    m1_req = 1; m1_we = 0; m1_addr = 8'h20;
    #1;
    chk("rd_m1_gnt", m1_gnt, 1);
    tick();
    m1_req = 0;
    chk("rd_io_re", io_re, 1);
    chk("rd_io_we", io_we, 0);
    chk("rd_io_addr", io_addr, 8'h20);
    chk("rd_early_rvalid", {m0_rvalid, m1_rvalid}, 0);
    tick();
    chk("rd_m1_rvalid", m1_rvalid, 1);
    chk("rd_m1_rdata", m1_rdata, 8'h3C);
    chk("rd_m0_rvalid", m0_rvalid, 0);
    tick();
    chk("rd_rvalid_end", {m0_rvalid, m1_rvalid}, 0);

    // Both masters writing continuously: 4 grants each, alternating
    m0_req = 1; m0_we = 1; m0_addr = 8'h40; m0_wdata = 8'h04;
    m1_req = 1; m1_we = 1; m1_addr = 8'h50; m1_wdata = 8'h05;
    prev_sel = 0;
    for (int i = 0; i < 10; i++) begin
      exp_sel = ((i / 4) % 2) == 1;
      #1;
      chk($sformatf("burst_m0_gnt_%0d", i), m0_gnt, !exp_sel);
      chk($sformatf("burst_m1_gnt_%0d", i), m1_gnt, exp_sel);
      if (i > 0) chk($sformatf("burst_io_addr_%0d", i), io_addr, prev_sel ? 8'h50 : 8'h40);
      prev_sel = exp_sel;
      tick();
    end

    // M1 alone: unlimited back-to-back grants
    m0_req = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("solo_m1_gnt_%0d", i), {m0_gnt, m1_gnt}, 2'b01);
      tick();
    end
    m1_req = 0;
    tick();

    // M0 read 0x30, then M1 write next cycle: data must return to M0
    m0_req = 1; m0_we = 0; m0_addr = 8'h30;
    #1;
    chk("sw_m0_gnt", m0_gnt, 1);
    tick();
    m0_req = 0;
    m1_req = 1; m1_we = 1; m1_addr = 8'h60; m1_wdata = 8'h77;
    #1;
    chk("sw_m1_gnt", m1_gnt, 1);
    chk("sw_io_re", io_re, 1);
    chk("sw_io_addr_rd", io_addr, 8'h30);
    tick();
    m1_req = 0;
    chk("sw_m0_rvalid", m0_rvalid, 1);
    chk("sw_m0_rdata", m0_rdata, 8'h30);
    chk("sw_m1_rvalid", m1_rvalid, 0);
    chk("sw_io_we", io_we, 1);
    chk("sw_io_addr_wr", io_addr, 8'h60);
    tick();
    chk("sw_rvalid_end", {m0_rvalid, m1_rvalid}, 0);

    // Reset with a read in flight, requests pending from both masters
    m1_req = 1; m1_we = 0; m1_addr = 8'h20;
    tick();
    m1_req = 0;
    chk("fl_io_re", io_re, 1);
    #2;
    rst = 1'b1;
    m0_req = 1; m0_we = 1; m0_addr = 8'h11;
    m1_req = 1; m1_we = 1; m1_addr = 8'h22;
    #1;
    chk("fl_io_re_rst", io_re, 0);
    chk("fl_io_we_rst", io_we, 0);
    chk("fl_gnts_rst", {m0_gnt, m1_gnt}, 0);
    chk("fl_rvalid_rst", {m0_rvalid, m1_rvalid}, 0);
    tick();
    chk("fl_rvalid_hold", {m0_rvalid, m1_rvalid}, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_gnt", {m0_gnt, m1_gnt}, 2'b10);
    tick();
    chk("post_rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("post_rst_io_addr", io_addr, 8'h11);
    m0_req = 0; m1_req = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
